credit_event_accumulator: RTL
=============================

# credit_event_accumulator

Upstream feeder for the 4-bit credit counter. It collects single-credit return and consume events from NUM_SRC sources each cycle and holds them in pending accumulators. Each cycle it issues at most 3 increments and at most 3 decrements as registered incr/decr commands with valid strobes. It also sequences counter re-initialisation. Burst peaks are absorbed in the accumulators and drained over later cycles.

## Interface
- NUM_SRC, default 4: number of event sources; 1..4.
- PEND_W, default 4: width of each pending accumulator; must be ≥ 3.

- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- ret_valid  input  NUM_SRC  bit i high = source i returns one credit this cycle.
- cons_valid  input  NUM_SRC  bit i high = source i consumes one credit this cycle.
- hold  input  1  suppresses issue; events still accumulate.
- reinit_req  input  1  request counter re-initialisation.
- reinit_val  input  4  value for re-initialisation, sampled with reinit_req.
- incr_valid  output  1  registered; incr is meaningful.
- incr  output  2  registered increment amount, 1..3 when valid.
- decr_valid  output  1  registered; decr is meaningful.
- decr  output  2  registered decrement amount, 1..3 when valid.
- reinit  output  1  registered one-cycle re-initialisation strobe.
- initial_value  output  4  registered; value presented with reinit.
- pend_empty  output  1  registered; both accumulators are zero.
- ovf  output  1  sticky accumulator-overflow flag.

## Operation
- State: inc_pend[PEND_W-1:0], dec_pend[PEND_W-1:0], plus the registered outputs. There is no other FSM state.
- Per cycle: r = popcount(ret_valid), c = popcount(cons_valid).
- Sums are computed in PEND_W+1 bits: tot_i = inc_pend + r, tot_d = dec_pend + c.
- Normal cycle (reinit_req=0, hold=0):
  - iss_i = min(tot_i, 3), iss_d = min(tot_d, 3).
  - inc_pend <= tot_i − iss_i, dec_pend <= tot_d − iss_d.
  - incr <= iss_i[1:0], incr_valid <= (iss_i≠0).
  - decr <= iss_d[1:0], decr_valid <= (iss_d≠0).
  - reinit <= 0.
- Increment and decrement are never netted against each other. Both may be valid in the same cycle.
- Hold cycle (hold=1, reinit_req=0):
  - iss_i = iss_d = 0.
  - Accumulators take tot_i and tot_d.
  - incr_valid and decr_valid <= 0; incr and decr <= 0.
- Reinit cycle (reinit_req=1, which has priority over hold):
  - Pending contents from before this cycle are discarded.
  - inc_pend <= r, dec_pend <= c, so same-cycle events survive.
  - reinit <= 1, initial_value <= reinit_val.
  - incr_valid and decr_valid <= 0.
- Overflow: if the value to be stored exceeds 2^PEND_W−1, store 2^PEND_W−1 and set ovf. ovf clears only on rst.
- initial_value holds its last value when reinit=0.
- pend_empty <= (next inc_pend==0 && next dec_pend==0).
- incr and decr are 0 whenever their valid is 0.

## Timing
- Reset (async assert, release synchronous to clk):
  - inc_pend = dec_pend = 0.
  - incr_valid = decr_valid = reinit = ovf = 0.
  - incr = decr = 0, initial_value = 0, pend_empty = 1.
- Latency: an event at cycle N is issued on the outputs at N+1 at the earliest, if the accumulator is empty and hold is low.
- Back-to-back reinit_req: each produces a one-cycle reinit pulse; no issue occurs in those cycles.
- Drain rate: 3 per direction per cycle. A pending value of k drains in ceil(k/3) non-hold cycles, assuming no new events.
- rst asserted mid-burst clears all pending events immediately. Nothing is issued after release until new events arrive.

## Test plan
- Reset, idle: rst pulse then 5 idle cycles -> all outputs 0, pend_empty=1, ovf=0.
- Single event latency: ret_valid=4'b0001 at cycle N -> at N+1 incr_valid=1, incr=1, decr_valid=0; at N+2 incr_valid=0, pend_empty=1.
- Burst drain: ret_valid=4'b1111 and cons_valid=4'b0011 for one cycle.
  - Next cycle: incr=3, decr=2, both valid.
  - Following cycle: incr=1, decr_valid=0.
  - Then pend_empty=1.
- Hold and overflow (PEND_W=4): hold=1 with ret_valid=4'b1111 for 4 cycles.
  - Stored value reaches 15 with ovf=1; no valid strobes during hold.
  - After hold drops: incr=3 for 5 consecutive cycles, then pend_empty=1; ovf stays 1.
- Reinit priority: inc_pend=7, then reinit_req=1, hold=1, reinit_val=4'hA, ret_valid=4'b0011 in the same cycle.
  - Next cycle: reinit=1, initial_value=A, incr_valid=0.
  - Then, with hold=0: incr=2 once, then pend_empty=1.
- Async reset mid-drain: assert rst asynchronously while incr_valid=1 and inc_pend=9 -> outputs clear immediately; after release, no issue until new events arrive.

Source files
------------

// File: rtl/credit_event_accumulator.sv
// Credit event accumulator: gathers per-source return/consume events and
// issues them as registered incr/decr commands, at most 3 each per cycle.
module credit_event_accumulator #(
  parameter int NUM_SRC = 4,
  parameter int PEND_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] ret_valid,
  input  logic [NUM_SRC-1:0] cons_valid,
  input  logic               hold,
  input  logic               reinit_req,
  input  logic [3:0]         reinit_val,
  output logic               incr_valid,
  output logic [1:0]         incr,
  output logic               decr_valid,
  output logic [1:0]         decr,
  output logic               reinit,
  output logic [3:0]         initial_value,
  output logic               pend_empty,
  output logic               ovf
);

  localparam int SW = PEND_W + 1;
  localparam logic [PEND_W-1:0] PMAX = '1;

  logic [PEND_W-1:0] inc_q, inc_d;
  logic [PEND_W-1:0] dec_q, dec_d;
  logic              incr_valid_q, decr_valid_q;
  logic [1:0]        incr_q, decr_q;
  logic              reinit_q;
  logic [3:0]        init_q;
  logic              empty_q;
  logic              ovf_q;

  logic [SW-1:0] r, c;
  logic [SW-1:0] tot_i, tot_d;
  logic [SW-1:0] nxt_i, nxt_d;
  logic [1:0]    iss_i, iss_d;
  logic          sat_i, sat_d;

  function automatic logic [SW-1:0] popcnt(input logic [NUM_SRC-1:0] v);
    logic [SW-1:0] n;
    n = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      n = n + SW'(v[k]);
    end
    return n;
  endfunction

  function automatic logic [1:0] min3(input logic [SW-1:0] t);
    return (t > SW'(3)) ? 2'd3 : t[1:0];
  endfunction

  always_comb begin
    r     = popcnt(ret_valid);
    c     = popcnt(cons_valid);
    tot_i = {1'b0, inc_q} + r;
    tot_d = {1'b0, dec_q} + c;
    iss_i = 2'd0;
    iss_d = 2'd0;
    nxt_i = tot_i;
    nxt_d = tot_d;
    // Reinit drops old pending but keeps this cycle's events.
    if (reinit_req) begin
      nxt_i = r;
      nxt_d = c;
    end else if (!hold) begin
      iss_i = min3(tot_i);
      iss_d = min3(tot_d);
      nxt_i = tot_i - SW'(iss_i);
      nxt_d = tot_d - SW'(iss_d);
    end
    sat_i = nxt_i > {1'b0, PMAX};
    sat_d = nxt_d > {1'b0, PMAX};
    inc_d = sat_i ? PMAX : nxt_i[PEND_W-1:0];
    dec_d = sat_d ? PMAX : nxt_d[PEND_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inc_q        <= '0;
      dec_q        <= '0;
      incr_valid_q <= 1'b0;
      decr_valid_q <= 1'b0;
      incr_q       <= 2'd0;
      decr_q       <= 2'd0;
      reinit_q     <= 1'b0;
      init_q       <= 4'd0;
      empty_q      <= 1'b1;
      ovf_q        <= 1'b0;
    end else begin
      inc_q        <= inc_d;
      dec_q        <= dec_d;
      incr_valid_q <= iss_i != 2'd0;
      decr_valid_q <= iss_d != 2'd0;
      incr_q       <= iss_i;
      decr_q       <= iss_d;
      reinit_q     <= reinit_req;
      if (reinit_req) begin
        init_q <= reinit_val;
      end
      empty_q      <= (inc_d == '0) && (dec_d == '0);
      ovf_q        <= ovf_q | sat_i | sat_d;
    end
  end

  assign incr_valid    = incr_valid_q;
  assign incr          = incr_q;
  assign decr_valid    = decr_valid_q;
  assign decr          = decr_q;
  assign reinit        = reinit_q;
  assign initial_value = init_q;
  assign pend_empty    = empty_q;
  assign ovf           = ovf_q;

endmodule
